// File: rtl/bpsk_demod.sv
// bpsk_demod
//   Hard-decision BPSK demodulator with byte packing and framing.
//   Each accepted in-phase sample is sliced to one bit (yr > 0 -> 1).
//   A bit is flagged weak when |yr| < THRESH. Bits are packed LSB-first
//   into bytes, and bytes are grouped into frames of FRAME_BYTES bytes.
//
// Ports
//   CLK      in   rising-edge clock
//   RST      in   synchronous active-high reset
//   start_i  in   frame-start strobe; also restarts a frame in progress
//   valid_y  in   sample strobe, one cycle per symbol
//   yr       in   signed in-phase sample (used for the decision)
//   yi       in   signed quadrature sample (not used)
//   valid_o  out  one-cycle pulse when a byte is ready
//   data_o   out  decided byte; the first bit of the byte is in bit 0
//   weak_o   out  number of weak bits in data_o
//   last_o   out  pulses with valid_o on the final byte of a frame
//   busy_o   out  high while a frame is being received
module bpsk_demod #(
  parameter logic signed [10:0] THRESH      = 11'sd4,
  parameter int                 FRAME_BYTES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic               valid_y,
  input  logic signed [10:0] yr,
  input  logic signed [10:0] yi,
  output logic               valid_o,
  output logic [7:0]         data_o,
  output logic [3:0]         weak_o,
  output logic               last_o,
  output logic               busy_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] byte_cnt_r, byte_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic [3:0] wcnt_r, wcnt_s;
  logic       valid_r, valid_s;
  logic       last_r, last_s;
  logic [7:0] data_r, data_s;
  logic [3:0] weak_r, weak_s;

  // Counter/shift values after an optional restart, before the new sample.
  logic [2:0] base_bit_s;
  logic [7:0] base_byte_s;
  logic [7:0] base_shift_s;
  logic [3:0] base_wcnt_s;

  logic [10:0] neg_s;
  logic [9:0]  mag_s;
  logic        weak_bit_s;
  logic        dec_bit_s;
  logic        accept_s;
  logic        yi_unused_s;

  assign yi_unused_s = ^yi;
  assign neg_s       = 11'd0 - yr;

  // Sample magnitude, with the single unrepresentable value -1024 clipped to 1023.
  always_comb begin
    mag_s = 10'd0;
    if (yr[10]) begin
      if (yr == -11'sd1024) begin
        mag_s = 10'd1023;
      end else begin
        mag_s = neg_s[9:0];
      end
    end else begin
      mag_s = yr[9:0];
    end
  end

  assign weak_bit_s = ($signed({1'b0, mag_s}) < THRESH);
  assign dec_bit_s  = (yr > 11'sd0);
  // A sample is taken in RUN, or in the same cycle as a start strobe.
  assign accept_s   = valid_y && (start_i || (state_r == RUN));

  // Next-state and next-output logic: restart first, then take the sample.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    shift_s      = shift_r;
    wcnt_s       = wcnt_r;
    valid_s      = 1'b0;
    last_s       = 1'b0;
    data_s       = data_r;
    weak_s       = weak_r;
    base_bit_s   = bit_cnt_r;
    base_byte_s  = byte_cnt_r;
    base_shift_s = shift_r;
    base_wcnt_s  = wcnt_r;

    // A start strobe discards any partial byte, so a coinciding 8th sample
    // becomes bit 0 of the new frame instead of completing the old byte.
    if (start_i) begin
      state_s      = RUN;
      base_bit_s   = 3'd0;
      base_byte_s  = 8'd0;
      base_shift_s = 8'd0;
      base_wcnt_s  = 4'd0;
    end else begin
      state_s = state_r;
    end

    bit_cnt_s  = base_bit_s;
    byte_cnt_s = base_byte_s;
    shift_s    = base_shift_s;
    wcnt_s     = base_wcnt_s;

    if (accept_s) begin
      shift_s[base_bit_s] = dec_bit_s;
      wcnt_s              = base_wcnt_s + {3'd0, weak_bit_s};
      bit_cnt_s           = base_bit_s + 3'd1;
      if (base_bit_s == 3'd7) begin
        valid_s = 1'b1;
        data_s  = shift_s;
        weak_s  = wcnt_s;
        shift_s = 8'd0;
        wcnt_s  = 4'd0;
        if (base_byte_s == LAST_BYTE) begin
          last_s     = 1'b1;
          state_s    = IDLE;
          byte_cnt_s = 8'd0;
        end else begin
          byte_cnt_s = base_byte_s + 8'd1;
        end
      end else begin
        valid_s = 1'b0;
      end
    end else begin
      valid_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 8'd0;
      shift_r    <= 8'd0;
      wcnt_r     <= 4'd0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      data_r     <= 8'd0;
      weak_r     <= 4'd0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      wcnt_r     <= wcnt_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      data_r     <= data_s;
      weak_r     <= weak_s;
    end
  end

  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign data_o  = data_r;
  assign weak_o  = weak_r;
  assign busy_o  = (state_r == RUN);

endmodule

// File: doc/bpsk_demod.md
BPSK_DEMOD -- requirements
Module: bpsk_demod

Interface
REQ-001 SHALL have parameter THRESH, default 11'sd4: magnitude below which a sample is flagged weak (range 0..1023).
REQ-002 SHALL have parameter FRAME_BYTES, default 16: bytes per frame (range 1..255).
REQ-003 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  frame-start strobe, one cycle.
REQ-006 SHALL have port valid_y  input  1  sample valid, one cycle per symbol.
REQ-007 SHALL have port yr  input  11 signed  received in-phase sample.
REQ-008 SHALL have port yi  input  11 signed  received quadrature sample, unused by the decision.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse, byte ready.
REQ-010 SHALL have port data_o  output  8  decided byte; first bit of the byte in bit 0.
REQ-011 SHALL have port weak_o  output  4  count of weak bits in data_o (0..8).
REQ-012 SHALL have port last_o  output  1  high with valid_o on the final byte of a frame.
REQ-013 SHALL have port busy_o  output  1  high while in state RUN.

Function
REQ-014 SHALL implement two states: IDLE and RUN; reset enters IDLE.
REQ-015 In IDLE, valid_y SHALL be ignored; start_i SHALL move to RUN with bit_cnt=0, byte_cnt=0, shift register and weak count cleared.
REQ-016 In RUN, each valid_y SHALL produce one decision bit: 1 if yr>0, 0 if yr<=0 (inverse of mapping 0->-8, 1->+8).
REQ-017 Magnitude SHALL be |yr|, with -1024 saturated to 1023; a sample SHALL be weak when magnitude < THRESH (so yr=0 is always weak for THRESH>=1).
REQ-018 Decision bits SHALL be packed LSB-first: the k-th valid sample of a byte (k=0..7) SHALL land in data_o[k].
REQ-019 On the cycle in which the 8th valid sample of a byte is accepted, the block SHALL register data_o and weak_o and assert valid_o for exactly the next cycle (latency 1 clock from the 8th sample).
REQ-020 data_o and weak_o SHALL hold their values between valid_o pulses.
REQ-021 bit_cnt (3 bit) SHALL wrap 7->0 at each byte; byte_cnt SHALL increment per emitted byte.
REQ-022 When byte_cnt reaches FRAME_BYTES-1 and a byte is emitted, last_o SHALL pulse with valid_o and the state SHALL return to IDLE.
REQ-023 start_i in RUN SHALL restart the frame: the partial byte is discarded without a valid_o, and counters are cleared.
REQ-024 start_i and valid_y in the same cycle SHALL restart first, then take that sample as bit 0 of byte 0 (in IDLE or RUN).
REQ-025 If start_i coincides with the 8th sample of a byte, the byte SHALL be discarded (no valid_o), and the sample SHALL count as bit 0 of the new frame.
REQ-026 Non-consecutive valid_y SHALL be tolerated; gaps of any length SHALL not affect packing.
REQ-027 valid_o, last_o and busy_o SHALL never be asserted in IDLE except the valid_o/last_o pulse of the final byte.

Reset
REQ-028 RST high at a rising edge SHALL set state IDLE, valid_o=0, last_o=0, busy_o=0, data_o=0, weak_o=0, and all counters and the shift register to 0.
REQ-029 RST SHALL take priority over start_i and valid_y; a partial byte or frame in progress SHALL be discarded with no output pulse.

Verification
REQ-030 FRAME_BYTES=2, start_i, then 16 samples yr = +8,-8,-8,+8,+8,+8,-8,-8 repeated -> valid_o twice with data_o=8'h39, weak_o=0; last_o on the second pulse only; busy_o low afterwards.
REQ-031 Samples yr = 0, +3, -3, +4, -4, +1023, -1024, +8 with THRESH=4 -> data_o=8'hAA, weak_o=3.
REQ-032 Eight valid_y with no preceding start_i -> no valid_o; busy_o stays 0.
REQ-033 start_i, 5 samples of +8, start_i with valid_y yr=-8, then 7 samples of +8 -> a single valid_o with data_o=8'hFE.
REQ-034 RST asserted after 4 samples of a byte, then start_i and 8 samples of +8 -> the first valid_o carries data_o=8'hFF with byte_cnt restarted (last_o when FRAME_BYTES=1).
REQ-035 Samples spaced with random 0..5-cycle gaps and random yi values -> data_o identical to the gap-free run; valid_o one cycle after each 8th sample.
